instr_fetch_ctrl: RTL and testbench

- Fetch controller for the multi-cycle MIPS datapath; the producer side of the program-counter update interface.
- Drives NPC[31:2] and PCWr into the PC register and reads the current PC back.
- Issues word fetches to instruction memory over a req/ack handshake and delivers instructions to decode over a valid/ready handshake.
- Applies branch/jump redirects from the execute stage.

---
 rtl/instr_fetch_ctrl_pkg.sv | 21 ++
 rtl/instr_fetch_ctrl_if.sv | 31 +++
 rtl/fetch_timeout_tmr.sv | 30 +++
 rtl/instr_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller, the PC register and NPC logic.
package instr_fetch_ctrl_pkg;

    localparam int WA_W = 30;

    typedef logic [WA_W-1:0] word_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_HOLD = 3'd2,
        ST_SYNC = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

    // Sequential word advance; wraps 3FFF_FFFF -> 0 by truncation.
    function automatic word_addr_t next_word(input word_addr_t addr);
        return addr + word_addr_t'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch controller bus: PC update, instruction memory, decode and redirect.
interface instr_fetch_ctrl_if;
    import instr_fetch_ctrl_pkg::*;

    logic [31:0] pc_i;
    word_addr_t  npc_o;
    logic        pcwr_o;
    logic        imem_req;
    word_addr_t  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir_o;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect_valid;
    word_addr_t  redirect_target;
    logic        fetch_err;

    // Controller side.
    modport master (
        input  pc_i, imem_ack, imem_rdata, ir_ready, redirect_valid, redirect_target,
        output npc_o, pcwr_o, imem_req, imem_addr, ir_o, ir_valid, fetch_err
    );

    // Environment side: PC register, instruction memory, decode, execute.
    modport slave (
        output pc_i, imem_ack, imem_rdata, ir_ready, redirect_valid, redirect_target,
        input  npc_o, pcwr_o, imem_req, imem_addr, ir_o, ir_valid, fetch_err
    );

endinterface

// File: rtl/fetch_timeout_tmr.sv
// Counts cycles spent waiting for imem_ack and flags when the limit is hit.
module fetch_timeout_tmr #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TMR_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(ACK_TIMEOUT);

    logic [TMR_W-1:0] timer;

    // Count while a request is outstanding; saturate at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (run && (timer != LIMIT)) begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign expired = run && (timer == LIMIT);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: issues word fetches, hands instructions to decode,
// advances or redirects the PC through npc_o/pcwr_o.
//
//   state | meaning
//   IDLE  | first cycle after reset release
//   REQ   | imem_req held, waiting for imem_ack
//   HOLD  | instruction offered to decode, waiting for ir_ready
//   SYNC  | one cycle for the PC register to absorb a redirect write
//   ERR   | ack timeout; everything quiet until reset
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TMR_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_ctrl_if.master bus
);

    fetch_state_t state;
    logic         squash;
    word_addr_t   saved_target;
    word_addr_t   npc_q;
    logic         pcwr_q;
    logic         req_q;
    logic [31:0]  ir_q;
    logic         ir_valid_q;
    logic         err_q;

    logic         tmr_run;
    logic         tmr_clear;
    logic         tmr_expired;

    word_addr_t   pc_word;
    logic [1:0]   unused_pc_lsb;

    assign pc_word       = bus.pc_i[31:2];
    assign unused_pc_lsb = bus.pc_i[1:0];

    assign tmr_run   = (state == ST_REQ);
    assign tmr_clear = (state != ST_REQ) || bus.imem_ack;

    fetch_timeout_tmr #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .run    (tmr_run),
        .clear  (tmr_clear),
        .expired(tmr_expired)
    );

    // Fetch sequencing; redirects beat both sequential advance and a same-cycle ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            squash       <= 1'b0;
            saved_target <= '0;
            npc_q        <= '0;
            pcwr_q       <= 1'b0;
            req_q        <= 1'b0;
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pcwr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.redirect_valid) begin
                        npc_q  <= bus.redirect_target;
                        pcwr_q <= 1'b1;
                        state  <= ST_SYNC;
                    end else begin
                        req_q <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tmr_expired && !bus.imem_ack) begin
                        err_q      <= 1'b1;
                        req_q      <= 1'b0;
                        ir_valid_q <= 1'b0;
                        squash     <= 1'b0;
                        state      <= ST_ERR;
                    end else if (bus.imem_ack) begin
                        req_q  <= 1'b0;
                        squash <= 1'b0;
                        pcwr_q <= 1'b1;
                        if (bus.redirect_valid) begin
                            npc_q <= bus.redirect_target;
                            state <= ST_SYNC;
                        end else if (squash) begin
                            npc_q <= saved_target;
                            state <= ST_SYNC;
                        end else begin
                            ir_q       <= bus.imem_rdata;
                            ir_valid_q <= 1'b1;
                            npc_q      <= next_word(pc_word);
                            state      <= ST_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        // The request cannot be withdrawn; drop its data on arrival.
                        saved_target <= bus.redirect_target;
                        squash       <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.redirect_valid) begin
                        ir_valid_q <= 1'b0;
                        npc_q      <= bus.redirect_target;
                        pcwr_q     <= 1'b1;
                        state      <= ST_SYNC;
                    end else if (bus.ir_ready) begin
                        ir_valid_q <= 1'b0;
                        req_q      <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_SYNC: begin
                    if (bus.redirect_valid) begin
                        npc_q  <= bus.redirect_target;
                        pcwr_q <= 1'b1;
                    end else begin
                        req_q <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_ERR: begin
                    req_q      <= 1'b0;
                    ir_valid_q <= 1'b0;
                end
                default: begin
                    req_q      <= 1'b0;
                    ir_valid_q <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.npc_o     = npc_q;
    assign bus.pcwr_o    = pcwr_q;
    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_q ? pc_word : '0;
    assign bus.ir_o      = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a
// randomized run checked against an instruction-stream model.
module tb_instr_fetch_ctrl;

    localparam int ACK_TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_reg;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(
        .ACK_TIMEOUT(ACK_TO),
        .TMR_W      (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // PC register on the other side of npc_o/pcwr_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_reg <= 32'h0000_3000;
        else if (bus.pcwr_o) pc_reg <= {bus.npc_o, 2'b00};
    end
    assign bus.pc_i = pc_reg;

    // Instruction memory contents as a function of the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h9E37_79B9;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.npc_o, bus.pcwr_o, bus.imem_req, bus.imem_addr, bus.ir_o, bus.ir_valid, bus.fetch_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: npc=%h pcwr=%b req=%b addr=%h ir=%h v=%b err=%b, want all 0",
                     bus.npc_o, bus.pcwr_o, bus.imem_req, bus.imem_addr, bus.ir_o, bus.ir_valid, bus.fetch_err);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C00) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h, want 1 / 0c00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h2408_0005;
        bus.ir_ready = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_checks++;
        if (bus.ir_o !== 32'h2408_0005 || bus.ir_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL zw_ir: ir=%h v=%b, want 24080005 / 1", bus.ir_o, bus.ir_valid);
        end
        n_checks++;
        if (bus.npc_o !== 30'h0C01 || bus.pcwr_o !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_npc: npc=%h pcwr=%b req=%b, want 0c01 / 1 / 0", bus.npc_o, bus.pcwr_o, bus.imem_req);
        end
        @(negedge clk);
        bus.ir_ready = 1'b0;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C01 || bus.pcwr_o !== 1'b0 || bus.ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_next_req: req=%b addr=%h pcwr=%b v=%b, want 1 / 0c01 / 0 / 0",
                     bus.imem_req, bus.imem_addr, bus.pcwr_o, bus.ir_valid);
        end
    endtask

    task automatic test_backpressure();
        int pulses = 0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(30'h0C01);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.pcwr_o) pulses++;
            n_checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir_o !== mem_word(30'h0C01) || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: v=%b ir=%h req=%b, want 1 / %h / 0",
                         i, bus.ir_valid, bus.ir_o, bus.imem_req, mem_word(30'h0C01));
            end
            @(negedge clk);
        end
        if (bus.pcwr_o) pulses++;
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL bp_pcwr_pulses: got %0d, want 1", pulses);
        end
        bus.ir_ready = 1'b1;
        @(negedge clk);
        bus.ir_ready = 1'b0;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C02 || bus.ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_req: req=%b addr=%h v=%b, want 1 / 0c02 / 0", bus.imem_req, bus.imem_addr, bus.ir_valid);
        end
    endtask

    task automatic test_redirect_wait();
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 30'h0C40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.pcwr_o !== 1'b0 || bus.ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_req_held: req=%b pcwr=%b v=%b, want 1 / 0 / 0", bus.imem_req, bus.pcwr_o, bus.ir_valid);
        end
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(30'h0C02);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_checks++;
        if (bus.ir_valid !== 1'b0 || bus.npc_o !== 30'h0C40 || bus.pcwr_o !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_squash: v=%b npc=%h pcwr=%b req=%b, want 0 / 0c40 / 1 / 0",
                     bus.ir_valid, bus.npc_o, bus.pcwr_o, bus.imem_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C40 || bus.pcwr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_target_req: req=%b addr=%h pcwr=%b, want 1 / 0c40 / 0", bus.imem_req, bus.imem_addr, bus.pcwr_o);
        end
    endtask

    task automatic test_redirect_ack();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(30'h0C40);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 30'h0C80;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.ir_valid !== 1'b0 || bus.npc_o !== 30'h0C80 || bus.pcwr_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ra_drop: v=%b npc=%h pcwr=%b, want 0 / 0c80 / 1", bus.ir_valid, bus.npc_o, bus.pcwr_o);
        end
        @(negedge clk);
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C80) begin
            n_fail++;
            $display("FAIL ra_target_req: req=%b addr=%h, want 1 / 0c80", bus.imem_req, bus.imem_addr);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(30'h0C80);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_checks++;
        if (bus.ir_o !== mem_word(30'h0C80) || bus.ir_valid !== 1'b1 || bus.npc_o !== 30'h0C81) begin
            n_fail++;
            $display("FAIL ra_deliver: ir=%h v=%b npc=%h, want %h / 1 / 0c81",
                     bus.ir_o, bus.ir_valid, bus.npc_o, mem_word(30'h0C80));
        end
    endtask

    task automatic test_redirect_hold();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 30'h0D00;
        bus.ir_ready = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.ir_ready = 1'b0;
        n_checks++;
        if (bus.ir_valid !== 1'b0 || bus.npc_o !== 30'h0D00 || bus.pcwr_o !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rh_override: v=%b npc=%h pcwr=%b req=%b, want 0 / 0d00 / 1 / 0",
                     bus.ir_valid, bus.npc_o, bus.pcwr_o, bus.imem_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0D00 || bus.pcwr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rh_target_req: req=%b addr=%h pcwr=%b, want 1 / 0d00 / 0", bus.imem_req, bus.imem_addr, bus.pcwr_o);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(30'h0D00);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_checks++;
        if (bus.ir_o !== mem_word(30'h0D00) || bus.npc_o !== 30'h0D01) begin
            n_fail++;
            $display("FAIL rh_deliver: ir=%h npc=%h, want %h / 0d01", bus.ir_o, bus.npc_o, mem_word(30'h0D00));
        end
    endtask

    // Model: decode sees mem_word(a), mem_word(a+1), ... from the last redirect target.
    task automatic test_random();
        logic [29:0] exp_addr;
        logic [29:0] tgt;
        int wcnt = 0;
        int lat = 0;
        int ndeliv = 0;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 30'($urandom);
        exp_addr = bus.redirect_target;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                if (wcnt >= lat) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    wcnt = 0;
                    lat = int'($urandom_range(0, ACK_TO - 1));
                end else begin
                    bus.imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                wcnt = 0;
            end
            bus.ir_ready = ($urandom_range(0, 1) == 1);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE + 30'($urandom_range(0, 1)) : 30'($urandom);
            bus.redirect_target = tgt;
            if (bus.imem_req) begin
                n_checks++;
                if (bus.imem_addr !== pc_reg[31:2]) begin
                    n_fail++;
                    $display("FAIL rnd_addr[%0d]: addr=%h, want %h", cyc, bus.imem_addr, pc_reg[31:2]);
                end
            end
            if (bus.ir_valid && bus.ir_ready) begin
                n_checks++;
                if (bus.ir_o !== mem_word(exp_addr)) begin
                    n_fail++;
                    $display("FAIL rnd_stream[%0d]: ir=%h, want %h (word %h)", cyc, bus.ir_o, mem_word(exp_addr), exp_addr);
                end
                exp_addr = exp_addr + 30'd1;
                ndeliv++;
            end
            if (bus.redirect_valid) exp_addr = tgt;
            n_checks++;
            if (bus.fetch_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_err[%0d]: fetch_err=%b, want 0", cyc, bus.fetch_err);
            end
        end
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.ir_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (ndeliv < 50) begin
            n_fail++;
            $display("FAIL rnd_progress: delivered %0d, want at least 50", ndeliv);
        end
    endtask

    task automatic test_timeout();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < ACK_TO + 1; i++) begin
            n_checks++;
            if (bus.imem_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait[%0d]: req=%b err=%b, want 1 / 0", i, bus.imem_req, bus.fetch_err);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL to_fault: err=%b req=%b v=%b, want 1 / 0 / 0", bus.fetch_err, bus.imem_req, bus.ir_valid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 30'h0123;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.pcwr_o !== 1'b0 || bus.npc_o !== 30'h0 || bus.fetch_err !== 1'b1 || bus.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_ignore_redirect: pcwr=%b npc=%h err=%b req=%b, want 0 / 0 / 1 / 0",
                     bus.pcwr_o, bus.npc_o, bus.fetch_err, bus.imem_req);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (bus.fetch_err !== 1'b0 || bus.imem_req !== 1'b0 || bus.pcwr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL to_async_reset: err=%b req=%b pcwr=%b, want 0 / 0 / 0", bus.fetch_err, bus.imem_req, bus.pcwr_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 30'h0C00 || bus.fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_restart: req=%b addr=%h err=%b, want 1 / 0c00 / 0", bus.imem_req, bus.imem_addr, bus.fetch_err);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_redirect_hold();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
